// File: rtl/ks_datapath.sv
// K&S processor datapath: PC, IR, 4x16 register file, ALU and flags register.
// Decode, RAM address and store data are combinational from registered state.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_BRANCH = 4'd1,
    I_BZERO  = 4'd2,
    I_BNEG   = 4'd3,
    I_LOAD   = 4'd4,
    I_STORE  = 4'd5,
    I_MOVE   = 4'd6,
    I_ADD    = 4'd7,
    I_SUB    = 4'd8,
    I_AND    = 4'd9,
    I_OR     = 4'd10,
    I_HALT   = 4'd11
  } decoded_instruction_type;
endpackage

module ks_datapath
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0]       ir_r;
  logic [ADDR_W-1:0]       pc_r;
  logic [DATA_W-1:0]       regs_r [4];
  logic [3:0]              flags_r;

  decoded_instruction_type dec_s;
  logic [1:0]              a_addr_s;
  logic [1:0]              b_addr_s;
  logic [1:0]              c_addr_s;
  logic [ADDR_W-1:0]       mem_addr_s;

  logic [DATA_W-1:0]       bus_a_s;
  logic [DATA_W-1:0]       bus_b_s;
  logic [DATA_W:0]         alu_wide_s;
  logic [DATA_W-1:0]       alu_res_s;
  logic                    alu_zero_s;
  logic                    alu_neg_s;
  logic                    alu_uov_s;
  logic                    alu_sov_s;
  logic [DATA_W-1:0]       wr_data_s;
  logic                    unused_ir_bit_s;

  // Instruction decode and register/memory field extraction
  always_comb begin
    dec_s      = I_NOP;
    a_addr_s   = 2'd0;
    b_addr_s   = 2'd0;
    c_addr_s   = 2'd0;
    mem_addr_s = {ADDR_W{1'b0}};
    case (ir_r[15:8])
      8'h00: dec_s = I_NOP;
      8'h01: begin dec_s = I_BRANCH; mem_addr_s = ir_r[ADDR_W-1:0]; end
      8'h02: begin dec_s = I_BZERO;  mem_addr_s = ir_r[ADDR_W-1:0]; end
      8'h03: begin dec_s = I_BNEG;   mem_addr_s = ir_r[ADDR_W-1:0]; end
      8'h81: begin dec_s = I_LOAD;   c_addr_s = ir_r[6:5]; mem_addr_s = ir_r[ADDR_W-1:0]; end
      8'h82: begin dec_s = I_STORE;  a_addr_s = ir_r[6:5]; mem_addr_s = ir_r[ADDR_W-1:0]; end
      8'h83: begin
        dec_s    = I_MOVE;
        c_addr_s = ir_r[3:2];
        a_addr_s = ir_r[1:0];
        b_addr_s = ir_r[1:0];
      end
      8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
        case (ir_r[15:8])
          8'hA1:   dec_s = I_ADD;
          8'hA2:   dec_s = I_SUB;
          8'hA3:   dec_s = I_AND;
          default: dec_s = I_OR;
        endcase
        c_addr_s = ir_r[5:4];
        a_addr_s = ir_r[3:2];
        b_addr_s = ir_r[1:0];
      end
      8'hFF:   dec_s = I_HALT;
      default: dec_s = I_NOP;
    endcase
  end

  assign bus_a_s = regs_r[a_addr_s];
  assign bus_b_s = regs_r[b_addr_s];

  // ALU: one extra bit carries the add carry-out or the subtract borrow
  always_comb begin
    alu_wide_s = {(DATA_W+1){1'b0}};
    alu_uov_s  = 1'b0;
    alu_sov_s  = 1'b0;
    case (operation)
      2'b00: begin
        alu_wide_s = {1'b0, bus_a_s} + {1'b0, bus_b_s};
        alu_uov_s  = alu_wide_s[DATA_W];
        alu_sov_s  = (bus_a_s[MSB] == bus_b_s[MSB]) && (alu_wide_s[MSB] != bus_a_s[MSB]);
      end
      2'b01: begin
        alu_wide_s = {1'b0, bus_a_s} - {1'b0, bus_b_s};
        alu_uov_s  = alu_wide_s[DATA_W];
        alu_sov_s  = (bus_a_s[MSB] != bus_b_s[MSB]) && (alu_wide_s[MSB] != bus_a_s[MSB]);
      end
      2'b10:   alu_wide_s = {1'b0, bus_a_s & bus_b_s};
      2'b11:   alu_wide_s = {1'b0, bus_a_s | bus_b_s};
      default: alu_wide_s = {(DATA_W+1){1'b0}};
    endcase
  end

  assign alu_res_s  = alu_wide_s[DATA_W-1:0];
  assign alu_zero_s = (alu_res_s == {DATA_W{1'b0}});
  assign alu_neg_s  = alu_res_s[MSB];
  assign wr_data_s  = c_sel ? data_in : alu_res_s;

  // Architectural state; reset wins over every enable, including a pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_r    <= {DATA_W{1'b0}};
      pc_r    <= {ADDR_W{1'b0}};
      flags_r <= 4'b0000;
      for (int i = 0; i < 4; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else begin
      if (ir_enable) ir_r <= data_in;
      if (pc_enable) pc_r <= branch ? mem_addr_s : pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (write_reg_enable) regs_r[c_addr_s] <= wr_data_s;
      if (flags_reg_enable) flags_r <= {alu_zero_s, alu_neg_s, alu_uov_s, alu_sov_s};
    end
  end

  assign unused_ir_bit_s     = ir_r[7];
  assign ram_addr            = addr_sel ? mem_addr_s : pc_r;
  assign data_out            = bus_a_s;
  assign decoded_instruction = dec_s;
  assign zero_op             = flags_r[3];
  assign neg_op              = flags_r[2];
  assign unsigned_overflow   = flags_r[1];
  assign signed_overflow     = flags_r[0];

endmodule
